// File: rtl/bus_interface_unit_pkg.sv
// bus_interface_unit_pkg: shared encodings, reset address and lane helpers for the bus interface unit
package bus_interface_unit_pkg;
  localparam logic [63:0] RESET_PC_DEF = 64'hE000_0000_0000_0000;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;
  typedef enum logic [2:0] {IDLE, FETCH, FETCH_HI, DATA, DATA_HI} state_e;
  function automatic logic [7:0] size_mask(size_e s);
    return s == SZ_B ? 8'h01 : s == SZ_H ? 8'h03 : s == SZ_W ? 8'h0f : 8'hff;
  endfunction
  function automatic logic [63:0] replicate(logic [63:0] d, size_e s);
    return s == SZ_B ? {8{d[7:0]}} : s == SZ_H ? {4{d[15:0]}} : s == SZ_W ? {2{d[31:0]}} : d;
  endfunction
  function automatic logic [63:0] extend(logic [63:0] v, size_e s, logic sg);
    return s == SZ_B ? {{56{sg & v[7]}}, v[7:0]} :
           s == SZ_H ? {{48{sg & v[15]}}, v[15:0]} :
           s == SZ_W ? {{32{sg & v[31]}}, v[31:0]} : v;
  endfunction
endpackage

// File: rtl/bus_interface_unit_ifq.sv
// bus_ifq: instruction packet FIFO with flush, head visible combinationally
module bus_ifq #(
  parameter int QDEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic             vld_o,
  output logic             full_o,
  output logic [WIDTH-1:0] dat_o
);
  localparam int AW = $clog2(QDEPTH);
  logic [WIDTH-1:0] mem [QDEPTH];
  logic [AW-1:0] rd, wr;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign vld_o = cnt != '0;
  assign full_o = cnt == (AW+1)'(QDEPTH);
  assign dat_o = mem[rd];
  assign do_pop = pop_i && vld_o;
  assign do_push = push_i && (!full_o || do_pop);
  // pointers and occupancy; a flush empties the queue regardless of push/pop
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      rd <= '0;
      wr <= '0;
      cnt <= '0;
    end else begin
      rd <= rd + AW'(do_pop);
      wr <= wr + AW'(do_push);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  // packet storage
  always_ff @(posedge clk_i) if (do_push && !flush_i) mem[wr] <= push_dat_i;
endmodule

// File: rtl/bus_interface_unit.sv
// bus_interface_unit: single-master bus sequencer for instruction prefetch and CPU loads/stores
module bus_interface_unit
  import bus_interface_unit_pkg::*;
#(
  parameter int          DW = 64,
  parameter int          QDEPTH = 4,
  parameter logic [63:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  output logic [63-$clog2(DW/8):0]    adr_o,
  output logic                        cyc_o,
  output logic                        stb_o,
  output logic [DW/8-1:0]             sel_o,
  output logic                        we_o,
  output logic                        vpa_o,
  output logic [DW-1:0]               dat_o,
  input  logic [DW-1:0]               dat_i,
  input  logic                        ack_i,
  input  logic                        req_i,
  input  logic                        req_we_i,
  input  logic [1:0]                  req_size_i,
  input  logic                        req_signed_i,
  input  logic [63:0]                 req_adr_i,
  input  logic [63:0]                 req_dat_i,
  output logic                        req_rdy_o,
  output logic                        rsp_vld_o,
  output logic [63:0]                 rsp_dat_o,
  output logic                        misalign_o,
  input  logic                        flush_i,
  input  logic [63:0]                 flush_adr_i,
  output logic                        ifq_vld_o,
  output logic [63:0]                 ifq_dat_o,
  input  logic                        ifq_pop_i
);
  localparam int LB = $clog2(DW / 8);
  localparam int SW = DW / 8;
  localparam int AW = 64 - LB;
  state_e state;
  size_e size_q, rsz;
  logic sgn_q, discard_q, full, acc, mis, hi, drop, push, dword;
  logic [2:0] off_q;
  logic [31:0] dq;
  logic [63:0] fp, lo_q, nfp, bus64, rep, ld;
  assign stb_o = cyc_o;
  assign req_rdy_o = state == IDLE && !misalign_o && !rsp_vld_o && !reset_i;
  // request decode, read-data assembly and lane steering
  always_comb begin
    rsz = size_e'(req_size_i);
    acc = req_i && req_rdy_o;
    mis = |(req_adr_i[2:0] & 3'((4'd1 << req_size_i) - 4'd1));
    nfp = flush_i ? flush_adr_i & ~64'h7 : fp;
    hi = state == FETCH_HI || state == DATA_HI;
    drop = discard_q || flush_i;
    dword = DW == 32 && size_q == SZ_D;
    push = cyc_o && ack_i && !drop && (state == FETCH_HI || (state == FETCH && DW == 64));
    bus64 = hi ? (64'(dat_i) << 32) | lo_q : 64'(dat_i);
    rep = replicate(req_dat_i, rsz);
    ld = extend(bus64 >> {off_q[LB-1:0], 3'b000}, size_q, sgn_q);
  end
  // bus sequencer: every bus output is registered and held until ack
  always_ff @(posedge clk_i) begin
    rsp_vld_o <= 1'b0;
    misalign_o <= 1'b0;
    if (reset_i) begin
      state <= FETCH;
      cyc_o <= 1'b1;
      vpa_o <= 1'b1;
      we_o <= 1'b0;
      sel_o <= '1;
      adr_o <= RESET_PC[63:LB];
      dat_o <= '0;
      fp <= RESET_PC;
      discard_q <= 1'b0;
      rsp_dat_o <= '0;
    end else begin
      fp <= flush_i ? nfp : push ? fp + 64'd8 : fp;
      discard_q <= state != IDLE && drop;
      case (state)
        IDLE:
          if (acc && mis) misalign_o <= 1'b1;
          else if (acc) begin
            state <= DATA;
            cyc_o <= 1'b1;
            vpa_o <= 1'b0;
            we_o <= req_we_i;
            sel_o <= SW'(size_mask(rsz) << req_adr_i[LB-1:0]);
            adr_o <= req_adr_i[63:LB];
            dat_o <= rep[DW-1:0];
            size_q <= rsz;
            sgn_q <= req_signed_i;
            off_q <= req_adr_i[2:0];
            dq <= req_dat_i[63:32];
          end else if (!full) begin
            state <= FETCH;
            cyc_o <= 1'b1;
            vpa_o <= 1'b1;
            we_o <= 1'b0;
            sel_o <= '1;
            adr_o <= nfp[63:LB];
          end
        FETCH:
          if (ack_i) begin
            cyc_o <= 1'b0;
            lo_q <= 64'(dat_i);
            state <= DW == 64 || drop ? IDLE : FETCH_HI;
          end
        FETCH_HI:
          if (!cyc_o) begin
            if (drop) state <= IDLE;
            else begin
              cyc_o <= 1'b1;
              adr_o <= adr_o + AW'(1);
            end
          end else if (ack_i) begin
            cyc_o <= 1'b0;
            state <= IDLE;
          end
        DATA:
          if (ack_i) begin
            cyc_o <= 1'b0;
            lo_q <= 64'(dat_i);
            if (dword) state <= DATA_HI;
            else begin
              state <= IDLE;
              rsp_vld_o <= 1'b1;
              rsp_dat_o <= we_o ? '0 : ld;
            end
          end
        DATA_HI:
          if (!cyc_o) begin
            cyc_o <= 1'b1;
            adr_o <= adr_o + AW'(1);
            dat_o <= DW'(dq);
          end else if (ack_i) begin
            cyc_o <= 1'b0;
            state <= IDLE;
            rsp_vld_o <= 1'b1;
            rsp_dat_o <= we_o ? '0 : ld;
          end
        default: state <= IDLE;
      endcase
    end
  end
  bus_ifq #(.QDEPTH(QDEPTH), .WIDTH(64)) u_ifq (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .flush_i(flush_i),
    .push_i(push),
    .push_dat_i(bus64),
    .pop_i(ifq_pop_i),
    .vld_o(ifq_vld_o),
    .full_o(full),
    .dat_o(ifq_dat_o)
  );
endmodule

// File: tb/tb_bus_interface_unit.sv
// tb_bus_interface_unit: directed scoreboard bench for the bus interface unit at DW=64 and DW=32
module tb_bus_interface_unit;
  localparam logic [63:0] RPC = 64'hE000_0000_0000_0000;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic req_we = 0, req_sg = 0, flush_a = 0;
  logic [1:0] req_sz = 0;
  logic [63:0] req_adr = 0, req_dat = 0, fadr = 0;
  logic [60:0] adr_a;
  logic cyc_a, stb_a, we_a, vpa_a, rdy_a, rsp_a, mis_a, qv_a;
  logic ack_a = 0, req_a = 0, pop_a = 0;
  logic [7:0] sel_a;
  logic [63:0] dat_oa, rdat_a, qd_a, dat_ia = 0;
  logic [61:0] adr_b;
  logic cyc_b, stb_b, we_b, vpa_b, rdy_b, rsp_b, mis_b, qv_b;
  logic ack_b = 0, req_b = 0;
  logic [3:0] sel_b;
  logic [31:0] dat_ob, dat_ib = 0;
  logic [63:0] rdat_b, qd_b;
  int n_cmp = 0, n_bad = 0;
  logic [63:0] s_adr, s_sel, s_we, s_vpa, s_dat;
  logic [63:0] exp_q[$], pkt_q[$];

  bus_interface_unit u_a (
    .clk_i(clk), .reset_i(rst), .adr_o(adr_a), .cyc_o(cyc_a), .stb_o(stb_a), .sel_o(sel_a),
    .we_o(we_a), .vpa_o(vpa_a), .dat_o(dat_oa), .dat_i(dat_ia), .ack_i(ack_a),
    .req_i(req_a), .req_we_i(req_we), .req_size_i(req_sz), .req_signed_i(req_sg),
    .req_adr_i(req_adr), .req_dat_i(req_dat), .req_rdy_o(rdy_a), .rsp_vld_o(rsp_a),
    .rsp_dat_o(rdat_a), .misalign_o(mis_a), .flush_i(flush_a), .flush_adr_i(fadr),
    .ifq_vld_o(qv_a), .ifq_dat_o(qd_a), .ifq_pop_i(pop_a)
  );
  bus_interface_unit #(.DW(32)) u_b (
    .clk_i(clk), .reset_i(rst), .adr_o(adr_b), .cyc_o(cyc_b), .stb_o(stb_b), .sel_o(sel_b),
    .we_o(we_b), .vpa_o(vpa_b), .dat_o(dat_ob), .dat_i(dat_ib), .ack_i(ack_b),
    .req_i(req_b), .req_we_i(req_we), .req_size_i(req_sz), .req_signed_i(req_sg),
    .req_adr_i(req_adr), .req_dat_i(req_dat), .req_rdy_o(rdy_b), .rsp_vld_o(rsp_b),
    .rsp_dat_o(rdat_b), .misalign_o(mis_b), .flush_i(1'b0), .flush_adr_i(64'd0),
    .ifq_vld_o(qv_b), .ifq_dat_o(qd_b), .ifq_pop_i(1'b0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic serve(input bit b, input logic [63:0] d);
    int n = 0;
    while (!(b ? cyc_b : cyc_a) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("bus_cycle_start", 64'(b ? cyc_b : cyc_a), 64'd1);
    s_adr = b ? 64'(adr_b) : 64'(adr_a);
    s_sel = b ? 64'(sel_b) : 64'(sel_a);
    s_we = b ? 64'(we_b) : 64'(we_a);
    s_vpa = b ? 64'(vpa_b) : 64'(vpa_a);
    s_dat = b ? 64'(dat_ob) : dat_oa;
    if (b) begin
      ack_b = 1;
      dat_ib = d[31:0];
    end else begin
      ack_a = 1;
      dat_ia = d;
    end
    @(negedge clk);
    ack_a = 0;
    ack_b = 0;
  endtask

  task automatic set_req(input bit b, input logic we, input logic [1:0] sz, input logic sg,
                         input logic [63:0] adr, input logic [63:0] dat);
    req_we = we;
    req_sz = sz;
    req_sg = sg;
    req_adr = adr;
    req_dat = dat;
    if (b) req_b = 1;
    else req_a = 1;
  endtask

  task automatic wait_acc(input bit b);
    int n = 0;
    while (!(b ? rdy_b : rdy_a) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("req_accept", 64'(b ? rdy_b : rdy_a), 64'd1);
    @(negedge clk);
    req_a = 0;
    req_b = 0;
  endtask

  task automatic wait_rsp(input bit b);
    int n = 0;
    logic [63:0] e;
    while (!(b ? rsp_b : rsp_a) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_vld", 64'(b ? rsp_b : rsp_a), 64'd1);
    e = exp_q.pop_front();
    chk("rsp_dat", b ? rdat_b : rdat_a, e);
    @(negedge clk);
    chk("rsp_one_cycle", 64'(b ? rsp_b : rsp_a), 64'd0);
  endtask

  task automatic data_op(input logic we, input logic [1:0] sz, input logic sg, input logic [63:0] adr,
                         input logic [63:0] wd, input logic [63:0] rd, input logic [63:0] exp_rsp,
                         input logic [7:0] exp_sel, input logic [63:0] exp_dat);
    set_req(0, we, sz, sg, adr, wd);
    exp_q.push_back(exp_rsp);
    wait_acc(0);
    serve(0, rd);
    chk("data_adr", s_adr, adr >> 3);
    chk("data_sel", s_sel, 64'(exp_sel));
    chk("data_we_vpa", {s_we[31:0], s_vpa[31:0]}, {31'd0, we, 32'd0});
    if (we) chk("store_dat", s_dat, exp_dat);
    wait_rsp(0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_cyc_stb", {62'd0, cyc_a, stb_a}, 64'd3);
    chk("rst_vpa_we", {62'd0, vpa_a, we_a}, 64'd2);
    chk("rst_sel", 64'(sel_a), 64'hff);
    chk("rst_adr_a", 64'(adr_a), RPC >> 3);
    chk("rst_adr_b", 64'(adr_b), RPC >> 2);
    chk("rst_rdy_rsp_mis_qv", {60'd0, rdy_a, rsp_a, mis_a, qv_a}, 64'd0);
    rst = 0;
    // DW=32: two-half fetch, then a dword load split across two bus cycles
    serve(1, 64'h1111_2222);
    chk("b_fetch_lo_adr", s_adr, RPC >> 2);
    chk("b_fetch_gap", 64'(cyc_b), 64'd0);
    set_req(1, 0, 2'd3, 0, 64'h5555_5550, 64'd0);
    exp_q.push_back(64'h8100_0000_0000_0001);
    serve(1, 64'h3333_4444);
    chk("b_fetch_hi_adr", s_adr, (RPC >> 2) + 64'd1);
    chk("b_packet", qd_b, 64'h3333_4444_1111_2222);
    wait_acc(1);
    serve(1, 64'h0000_0001);
    chk("b_dw_lo_adr", s_adr, 64'h5555_5550 >> 2);
    chk("b_dw_lo_sel", s_sel, 64'hf);
    chk("b_dw_gap", 64'(cyc_b), 64'd0);
    serve(1, 64'h8100_0000);
    chk("b_dw_hi_adr", s_adr, 64'h5555_5554 >> 2);
    wait_rsp(1);
    // DW=64: fill the queue from reset
    for (int k = 0; k < 4; k++) begin
      serve(0, 64'hA0A0_0000_0000_0000 | 64'(k));
      chk("fetch_adr", s_adr, (RPC >> 3) + 64'(k));
      chk("fetch_vpa_sel", {s_vpa[31:0], s_sel[31:0]}, {32'd1, 32'hff});
      pkt_q.push_back(64'hA0A0_0000_0000_0000 | 64'(k));
    end
    repeat (4) @(negedge clk);
    chk("full_no_cyc", 64'(cyc_a), 64'd0);
    chk("ifq_vld", 64'(qv_a), 64'd1);
    chk("ifq_head", qd_a, pkt_q[0]);
    pop_a = 1;
    @(negedge clk);
    pop_a = 0;
    void'(pkt_q.pop_front());
    chk("ifq_head_after_pop", qd_a, pkt_q[0]);
    serve(0, 64'hA0A0_0000_0000_0004);
    chk("fetch_after_pop_adr", s_adr, (RPC + 64'h20) >> 3);
    pkt_q.push_back(64'hA0A0_0000_0000_0004);
    // data traffic with the queue full
    data_op(1, 2'd0, 0, 64'h1111_1111, 64'h41, 64'd0, 64'd0, 8'h02, 64'h4141_4141_4141_4141);
    data_op(0, 2'd0, 1, 64'h5555_5555, 64'd0, 64'h0000_8100_0000_0000, 64'hFFFF_FFFF_FFFF_FF81, 8'h20, 64'd0);
    data_op(0, 2'd0, 0, 64'h5555_5555, 64'd0, 64'h0000_8100_0000_0000, 64'h81, 8'h20, 64'd0);
    data_op(1, 2'd2, 0, 64'h1004, 64'h1234_5678, 64'd0, 64'd0, 8'hf0, 64'h1234_5678_1234_5678);
    data_op(0, 2'd1, 1, 64'h2006, 64'd0, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001, 8'hc0, 64'd0);
    data_op(0, 2'd3, 0, 64'h3008, 64'd0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 8'hff, 64'd0);
    // misaligned half load
    set_req(0, 0, 2'd1, 0, 64'h0000_0000_0000_0003, 64'd0);
    wait_acc(0);
    chk("mis_pulse", {61'd0, mis_a, rdy_a, rsp_a}, 64'd4);
    chk("mis_no_cyc", 64'(cyc_a), 64'd0);
    @(negedge clk);
    chk("mis_after", {61'd0, mis_a, rdy_a, cyc_a}, 64'd2);
    // flush during an unacked fetch, with a competing pop
    pop_a = 1;
    @(negedge clk);
    pop_a = 0;
    void'(pkt_q.pop_front());
    for (int n = 0; n < 60 && !cyc_a; n++) @(negedge clk);
    chk("prefetch_adr", 64'(adr_a), (RPC + 64'h28) >> 3);
    flush_a = 1;
    fadr = 64'h4D;
    pop_a = 1;
    @(negedge clk);
    flush_a = 0;
    pkt_q.delete();
    chk("flush_empty", 64'(qv_a), 64'd0);
    chk("flush_cyc_held", 64'(cyc_a), 64'd1);
    @(negedge clk);
    pop_a = 0;
    chk("empty_pop_ignored", 64'(qv_a), 64'd0);
    serve(0, 64'hDEAD_BEEF_DEAD_BEEF);
    chk("flushed_data_dropped", 64'(qv_a), 64'd0);
    serve(0, 64'hB0B0_0000_0000_0048);
    chk("redirect_adr", s_adr, 64'h48 >> 3);
    pkt_q.push_back(64'hB0B0_0000_0000_0048);
    chk("redirect_push", {qd_a[62:0], qv_a}, {pkt_q[0][62:0], 1'b1});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
